// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/mem/writeback control FSM for the RISC-V core.
// Optional macro CORE_SEQ_TIMEOUT_EN adds a memory-handshake watchdog (fault causes 10 and 11).
module core_sequencer #(
   parameter int unsigned ADDR_SIZE      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        clear_fault,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] instr,
   output logic [31:0] ir,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        pc_enable,
   output logic        rf_we,
   output logic        busy,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StFetch     = 3'd1,
      StDecode    = 3'd2,
      StExecute   = 3'd3,
      StMem       = 3'd4,
      StWriteback = 3'd5,
      StFault     = 3'd6
   } state_e;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   localparam logic [1:0] CauseNone    = 2'b00;
   localparam logic [1:0] CauseIllegal = 2'b01;
   localparam logic [1:0] CauseImemTmo = 2'b10;
   localparam logic [1:0] CauseDmemTmo = 2'b11;

   state_e      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [1:0]  cause_q, cause_d;

   logic [6:0]  opcode;
   logic        op_legal;
   logic        op_mem;
   logic        op_store;
   logic        op_branch;
   logic        imem_tmo;
   logic        dmem_tmo;

   // Address width is carried only for interface consistency with the rest of the core.
   logic [63:0] unused_cfg;
   assign unused_cfg = {ADDR_SIZE, TIMEOUT_CYCLES};

   // ---------------------------------------------------------------------------------------------
   // Opcode classification from the held instruction register
   // ---------------------------------------------------------------------------------------------
   assign opcode    = ir_q[6:0];
   assign op_store  = (opcode == OpStore);
   assign op_branch = (opcode == OpBranch);
   assign op_mem    = (opcode == OpLoad) || op_store;

   always_comb begin
      op_legal = 1'b0;
      case (opcode)
         OpLui, OpAuipc, OpJal, OpJalr, OpBranch,
         OpLoad, OpStore, OpImm, OpReg: op_legal = 1'b1;
         default:                       op_legal = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------------------------
   // Memory-handshake watchdog
   // ---------------------------------------------------------------------------------------------
`ifdef CORE_SEQ_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            waiting;

   // Counter is zero outside a stalled FETCH/MEM, so every entry into those states starts at 0.
   assign waiting   = ((state_q == StFetch) && !imem_ready) ||
                      ((state_q == StMem)   && !dmem_ready);
   assign tmo_cnt_d = waiting ? tmo_cnt_q + 1'b1 : '0;
   assign imem_tmo  = (state_q == StFetch) && waiting &&
                      (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign dmem_tmo  = (state_q == StMem) && waiting &&
                      (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign imem_tmo = 1'b0;
   assign dmem_tmo = 1'b0;
`endif

   // ---------------------------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cause_d = cause_q;
      case (state_q)
         StIdle: begin
            if (run) state_d = StFetch;
         end
         StFetch: begin
            if (imem_ready) begin
               ir_d    = instr;
               state_d = StDecode;
            end else if (imem_tmo) begin
               cause_d = CauseImemTmo;
               state_d = StFault;
            end
         end
         StDecode: begin
            if (op_legal) begin
               state_d = StExecute;
            end else begin
               cause_d = CauseIllegal;
               state_d = StFault;
            end
         end
         StExecute: begin
            state_d = op_mem ? StMem : StWriteback;
         end
         StMem: begin
            if (dmem_ready) begin
               state_d = StWriteback;
            end else if (dmem_tmo) begin
               cause_d = CauseDmemTmo;
               state_d = StFault;
            end
         end
         StWriteback: begin
            state_d = run ? StFetch : StIdle;
         end
         StFault: begin
            if (clear_fault) begin
               cause_d = CauseNone;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ir_q    <= '0;
         cause_q <= CauseNone;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cause_q <= cause_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Moore outputs; requests fall immediately when reset forces the state to IDLE
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      imem_req  = (state_q == StFetch);
      dmem_req  = (state_q == StMem);
      dmem_we   = (state_q == StMem) && op_store;
      pc_enable = (state_q == StWriteback);
      rf_we     = (state_q == StWriteback) && !(op_branch || op_store);
      busy      = (state_q != StIdle) && (state_q != StFault);
      fault     = (state_q == StFault);
   end

   assign ir          = ir_q;
   assign fault_cause = cause_q;
   assign state       = state_q;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RISC-V core. Sequences each instruction through fetch, decode, execute, optional data-memory access and writeback. Holds the instruction register and drives the handshakes to instruction and data memory. Generates the single-cycle `pc_enable` and `rf_we` strobes that advance the program counter and commit register-file writes.

## Interface
Parameters:
- `ADDR_SIZE`, 32: width of the PC/address domain. Passed through for consistency; no address datapath in this block.
- `TIMEOUT_CYCLES`, 16: memory-handshake watchdog limit. Used only when `CORE_SEQ_TIMEOUT_EN` is defined. Must be ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `run` in 1: level; allows new instructions to start.
- `clear_fault` in 1: leaves FAULT; ignored in all other states.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: fetch complete; `instr` valid this cycle.
- `instr` in 32: fetched instruction word.
- `ir` out 32: instruction register, feeds decoder/ALU/PC.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a store.
- `dmem_ready` in 1: data access complete this cycle.
- `pc_enable` out 1: one-cycle PC advance strobe.
- `rf_we` out 1: one-cycle register-file write strobe.
- `busy` out 1: high in every state except IDLE and FAULT.
- `fault` out 1: high in FAULT.
- `fault_cause` out 2: 00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEM 4, WRITEBACK 5, FAULT 6. Encoding 7 is unused and recovers to IDLE.
- IDLE: if `run`=1, go to FETCH.
- FETCH: `imem_req`=1. When `imem_ready`=1, load `instr` into `ir` and go to DECODE. Otherwise stay.
- DECODE: check `ir[6:0]` against the legal opcodes 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011.
  - Illegal: go to FAULT with cause 01.
  - Legal: go to EXECUTE.
- EXECUTE: one cycle. LOAD (0000011) and STORE (0100011) go to MEM. All others go to WRITEBACK.
- MEM: `dmem_req`=1; `dmem_we`=1 for STORE only. When `dmem_ready`=1, go to WRITEBACK.
- WRITEBACK:
  - `pc_enable`=1.
  - `rf_we`=1 except for BRANCH (1100011) and STORE.
  - Next state is FETCH if `run`=1, else IDLE.
- FAULT: all strobes and requests are 0. `fault_cause` holds its value. `clear_fault`=1 goes to IDLE and clears the cause to 00.
- `run` deasserted mid-instruction: the current instruction completes through WRITEBACK, then the FSM goes to IDLE.
- `ir` changes only on a FETCH handshake. It holds in all other states, including FAULT.
- All outputs other than `ir`, `fault_cause` and the timeout counter are decoded combinationally from `state` and `ir` (Moore).

## Timing
- Reset values:
  - `state`=IDLE, `ir`=0, `fault_cause`=00, timeout counter = 0.
  - All requests and strobes 0; `busy`=0; `fault`=0.
- Asserting `rst_n` low forces IDLE immediately, independent of `clk`. An in-flight `imem_req`/`dmem_req` drops asynchronously and the instruction is discarded; no `pc_enable`.
- Latency with zero memory wait:
  - ALU, jump and branch instructions: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Load/store: 5 cycles.
  - Each cycle that `imem_ready`/`dmem_ready` is low adds 1 cycle.
- Request/ready rules:
  - A request is held high until the cycle in which ready is sampled high; it drops the following cycle.
  - Ready while no request is pending is ignored.
- Back-to-back: with `run` held, FETCH of the next instruction begins the cycle after WRITEBACK.
- `pc_enable` pulses exactly once per retired instruction and never in FAULT or IDLE.

## Configuration
- `CORE_SEQ_TIMEOUT_EN` defined:
  - A counter clears on entry to FETCH/MEM and increments each cycle the state's ready input is low.
  - When the counter reaches `TIMEOUT_CYCLES` with ready still low, go to FAULT with cause 10 (FETCH) or 11 (MEM).
  - Ready high in that same cycle wins: no fault.
- `CORE_SEQ_TIMEOUT_EN` not defined:
  - No counter logic; FETCH/MEM wait indefinitely.
  - Only cause 01 is reachable.

## Test plan
- Reset, `run`=1, ADDI 0x00500093 with `imem_ready` tied 1 → states 1,2,3,5. `pc_enable` and `rf_we` high together on cycle 4 only; `ir`=0x00500093.
- SW 0x00112023, `dmem_ready` delayed 3 cycles → `dmem_req`=`dmem_we`=1 for 4 cycles, then WRITEBACK with `pc_enable`=1 and `rf_we`=0.
- `instr`=0xFFFFFFFF → FAULT, `fault_cause`=01, `busy`=0. Pulse `clear_fault` → IDLE, cause 00.
- Timeout enabled with `TIMEOUT_CYCLES`=16, `imem_ready` held 0 → FAULT with cause 10 after 16 FETCH cycles. Repeat with ready high on the 16th cycle → no fault.
- `rst_n` low during MEM → `dmem_req` drops without a clock edge. After release: `state`=0, `ir`=0, no `pc_enable`.
- `run` dropped during EXECUTE of BEQ → WRITEBACK with `pc_enable`=1, `rf_we`=0, then IDLE, and no further `imem_req`.
